// File: rtl/ad7357_pkg.sv
// Shared types and constants for the AD7357 dual-channel serial capture block.
package ad7357_pkg;

  localparam int unsigned SampleW      = 14;
  localparam int unsigned DefaultNBits = 16;
  localparam int unsigned CntW         = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StQuiet
  } state_e;

  // QUIET must also cover the capture pipeline so the last bit lands before IDLE.
  function automatic int unsigned quiet_len(input int unsigned quiet, input int unsigned dly);
    return (quiet > dly + 1) ? quiet : dly + 1;
  endfunction

endpackage

// File: rtl/ad7357_shift_rx.sv
// Delayed shift enable, dual MSB-first shift register and frame-complete strobe.
module ad7357_shift_rx
  import ad7357_pkg::*;
#(
  parameter int unsigned N_BITS        = DefaultNBits,
  parameter int unsigned CAPTURE_DELAY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cken,
  input  logic              i_sdata_a,
  input  logic              i_sdata_b,
  output logic [N_BITS-1:0] o_frame_a,
  output logic [N_BITS-1:0] o_frame_b,
  output logic              o_done
);

  localparam logic [CntW-1:0] BitLast = CntW'(N_BITS - 1);

  logic [CAPTURE_DELAY-1:0] en_pipe_q;
  logic [N_BITS-1:0]        frame_a_q, frame_b_q;
  logic [CntW-1:0]          bit_cnt_q;
  logic                     done_q;
  logic                     shift_en;

  assign shift_en  = en_pipe_q[CAPTURE_DELAY-1];
  assign o_frame_a = frame_a_q;
  assign o_frame_b = frame_b_q;
  assign o_done    = done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_pipe_q <= '0;
      frame_a_q <= '0;
      frame_b_q <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      en_pipe_q <= CAPTURE_DELAY'({en_pipe_q, i_cken});
      done_q    <= 1'b0;
      if (shift_en) begin
        frame_a_q <= {frame_a_q[N_BITS-2:0], i_sdata_a};
        frame_b_q <= {frame_b_q[N_BITS-2:0], i_sdata_b};
        if (bit_cnt_q == BitLast) begin
          bit_cnt_q <= '0;
          done_q    <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ad7357_capture.sv
// AD7357 frame sequencer: drives CS/SCLK enable, collects both channels, presents
// samples over a valid/ready handshake with overrun and leading-zero error pulses.
module ad7357_capture
  import ad7357_pkg::*;
#(
  parameter int unsigned N_BITS        = DefaultNBits,
  parameter int unsigned CAPTURE_DELAY = 2,
  parameter int unsigned QUIET_CYCLES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_ctl_cken,
  output logic               o_adc_cs_n,
  input  logic               i_adc_sdata_a,
  input  logic               i_adc_sdata_b,
  output logic [SampleW-1:0] o_data_a,
  output logic [SampleW-1:0] o_data_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_lz_err,
  output logic               o_overrun
);

  localparam int unsigned     QuietLen  = quiet_len(QUIET_CYCLES, CAPTURE_DELAY);
  localparam logic [CntW-1:0] ShiftLast = CntW'(N_BITS - 1);
  localparam logic [CntW-1:0] QuietLast = CntW'(QuietLen - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            cken_q, cken_d;
  logic            cs_n_q, cs_n_d;

  logic [SampleW-1:0] data_a_q, data_b_q;
  logic               valid_q, lz_q, ovr_q;

  logic [N_BITS-1:0] frame_a, frame_b;
  logic              frame_done;
  logic              lead_nz;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      cken_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      cken_q  <= cken_d;
      cs_n_q  <= cs_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StSetup;
      end
      StSetup: begin
        state_d = StShift;
        cnt_d   = '0;
      end
      StShift: begin
        if (cnt_q == ShiftLast) begin
          state_d = StQuiet;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StQuiet: begin
        if (cnt_q == QuietLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d = 1'b0;
    cken_d = 1'b0;
    cs_n_d = 1'b1;
    unique case (state_d)
      StIdle: ;
      StSetup: begin
        busy_d = 1'b1;
        cs_n_d = 1'b0;
      end
      StShift: begin
        busy_d = 1'b1;
        cs_n_d = 1'b0;
        cken_d = 1'b1;
      end
      StQuiet: begin
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  ad7357_shift_rx #(
    .N_BITS       (N_BITS),
    .CAPTURE_DELAY(CAPTURE_DELAY)
  ) u_shift_rx (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_cken   (cken_q),
    .i_sdata_a(i_adc_sdata_a),
    .i_sdata_b(i_adc_sdata_b),
    .o_frame_a(frame_a),
    .o_frame_b(frame_b),
    .o_done   (frame_done)
  );

  assign lead_nz = (|frame_a[N_BITS-1:SampleW]) | (|frame_b[N_BITS-1:SampleW]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
      valid_q  <= 1'b0;
      lz_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      lz_q  <= 1'b0;
      ovr_q <= 1'b0;
      if (frame_done) begin
        lz_q <= lead_nz;
        if (!valid_q || i_ready) begin
          data_a_q <= frame_a[SampleW-1:0];
          data_b_q <= frame_b[SampleW-1:0];
          valid_q  <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_busy     = busy_q;
  assign o_ctl_cken = cken_q;
  assign o_adc_cs_n = cs_n_q;
  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_valid    = valid_q;
  assign o_lz_err   = lz_q;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_ad7357_capture.sv
// Bench for ad7357_capture: two configurations, an ADC line model and a timestamp-based
// reference model checked every cycle, plus table-driven and directed corner cases.
module tb_ad7357_capture;

  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [2];
  logic        ready [2];
  logic        sda   [2];
  logic        sdb   [2];
  logic        busy  [2];
  logic        cken  [2];
  logic        cs_n  [2];
  logic        valid [2];
  logic        lz    [2];
  logic        ovr   [2];
  logic [13:0] da    [2];
  logic [13:0] db    [2];

  ad7357_capture #(.N_BITS(16), .CAPTURE_DELAY(2), .QUIET_CYCLES(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_ctl_cken(cken[0]),
    .o_adc_cs_n(cs_n[0]), .i_adc_sdata_a(sda[0]), .i_adc_sdata_b(sdb[0]), .o_data_a(da[0]),
    .o_data_b(db[0]), .o_valid(valid[0]), .i_ready(ready[0]), .o_lz_err(lz[0]),
    .o_overrun(ovr[0])
  );

  ad7357_capture #(.N_BITS(16), .CAPTURE_DELAY(5), .QUIET_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_ctl_cken(cken[1]),
    .o_adc_cs_n(cs_n[1]), .i_adc_sdata_a(sda[1]), .i_adc_sdata_b(sdb[1]), .o_data_a(da[1]),
    .o_data_b(db[1]), .o_valid(valid[1]), .i_ready(ready[1]), .o_lz_err(lz[1]),
    .o_overrun(ovr[1])
  );

  // Per-instance configuration: capture delay and resulting quiet length.
  int dly  [2] = '{2, 5};
  int qlen [2] = '{3, 6};

  // ADC line model state
  logic [15:0] wa [2];
  logic [15:0] wb [2];
  int          idx [2];
  logic [8:0]  hist_a [2];
  logic [8:0]  hist_b [2];

  // Reference model state
  int          cyc;
  int          start_k [2];
  int          load_e  [2];
  bit          pend    [2];
  logic [15:0] pa [2];
  logic [15:0] pb [2];
  bit          m_valid [2];
  logic [13:0] m_da [2];
  logic [13:0] m_db [2];
  bit          m_lz [2], m_ov [2], m_busy [2], m_csn [2], m_cken [2];

  int vectors;
  int miscompares;

  typedef struct {
    logic [15:0] wa;
    logic [15:0] wb;
    logic [13:0] ea;
    logic [13:0] eb;
    int          elz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Frame timeline derived from the accepted start edge k.
  task automatic model_edge(input int i);
    int e;
    e = cyc;
    if (rst) begin
      start_k[i] = -1000;
      pend[i]    = 0;
      m_valid[i] = 0;
      m_da[i]    = '0;
      m_db[i]    = '0;
      m_lz[i]    = 0;
      m_ov[i]    = 0;
    end else begin
      m_lz[i] = 0;
      m_ov[i] = 0;
      if (pend[i] && e == load_e[i]) begin
        pend[i] = 0;
        m_lz[i] = (pa[i][15:14] != 2'b00) || (pb[i][15:14] != 2'b00);
        if (!m_valid[i] || ready[i]) begin
          m_valid[i] = 1;
          m_da[i]    = pa[i][13:0];
          m_db[i]    = pb[i][13:0];
        end else begin
          m_ov[i] = 1;
        end
      end else if (m_valid[i] && ready[i]) begin
        m_valid[i] = 0;
      end
      if (start[i] && e >= start_k[i] + N + qlen[i] + 2) begin
        start_k[i] = e;
        pend[i]    = 1;
        load_e[i]  = e + N + dly[i] + 2;
        pa[i]      = wa[i];
        pb[i]      = wb[i];
      end
    end
    m_csn[i]  = !(e >= start_k[i] && e <= start_k[i] + N);
    m_cken[i] = (e >= start_k[i] + 1 && e <= start_k[i] + N);
    m_busy[i] = (e <= start_k[i] + N + qlen[i]);
  endtask

  // ADC: one bit per SCLK-enabled cycle, MSB first, arriving dly cycles later.
  task automatic adc_drive(input int i);
    logic ba, bb;
    ba = 1'b0;
    bb = 1'b0;
    if (cs_n[i]) idx[i] = 0;
    if (cken[i] === 1'b1 && idx[i] < N) begin
      ba = wa[i][N-1-idx[i]];
      bb = wb[i][N-1-idx[i]];
      idx[i]++;
    end
    hist_a[i] = {hist_a[i][7:0], ba};
    hist_b[i] = {hist_b[i][7:0], bb};
    sda[i] = hist_a[i][dly[i]];
    sdb[i] = hist_b[i][dly[i]];
  endtask

  task automatic check_outputs(input int i);
    vectors++;
    if (busy[i] !== m_busy[i] || cs_n[i] !== m_csn[i] || cken[i] !== m_cken[i] ||
        valid[i] !== m_valid[i] || lz[i] !== m_lz[i] || ovr[i] !== m_ov[i] ||
        da[i] !== m_da[i] || db[i] !== m_db[i]) begin
      miscompares++;
      $display("FAIL model_dut%0d cycle %0d: got busy/csn/cken/valid/lz/ov=%b%b%b%b%b%b da=%h db=%h, expected %b%b%b%b%b%b da=%h db=%h",
               i, cyc, busy[i], cs_n[i], cken[i], valid[i], lz[i], ovr[i], da[i], db[i],
               m_busy[i], m_csn[i], m_cken[i], m_valid[i], m_lz[i], m_ov[i], m_da[i], m_db[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    adc_drive(0);
    adc_drive(1);
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
  endtask

  // One frame with ready held as-is; reports the first valid rise and pulse counts.
  task automatic run_frame(input int i, input logic [15:0] a, input logic [15:0] b,
                           output bit got, output logic [13:0] ga, output logic [13:0] gb,
                           output int lz_cnt, output int ov_cnt, output int q_cnt);
    bit prev;
    wa[i] = a;
    wb[i] = b;
    start[i] = 1'b1;
    prev = valid[i];
    step();
    start[i] = 1'b0;
    got = 0; ga = '0; gb = '0; lz_cnt = 0; ov_cnt = 0; q_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      if (valid[i] && !prev && !got) begin
        got = 1;
        ga  = da[i];
        gb  = db[i];
      end
      prev = valid[i];
      if (lz[i]) lz_cnt++;
      if (ovr[i]) ov_cnt++;
      if (busy[i] && cs_n[i]) q_cnt++;
      step();
    end
  endtask

  vec_t tbl [6];

  initial begin
    bit          got;
    logic [13:0] ga, gb;
    int          lzc, ovc, qc, t0, csf, csl, ckf, ckl, cnt, rises, bad, last_rise, min_gap, run;
    bit          prev_ck, seen_low;

    tbl[0] = '{16'h2ABC, 16'h1234, 14'h2ABC, 14'h1234, 0};
    tbl[1] = '{16'h0000, 16'h3FFF, 14'h0000, 14'h3FFF, 0};
    tbl[2] = '{16'h3FFF, 16'h0000, 14'h3FFF, 14'h0000, 0};
    tbl[3] = '{16'h1234, 16'h5678, 14'h1234, 14'h1678, 1};
    tbl[4] = '{16'h8001, 16'h0000, 14'h0001, 14'h0000, 1};
    tbl[5] = '{16'hC000, 16'hC000, 14'h0000, 14'h0000, 1};

    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; ready[i] = 1'b1; wa[i] = '0; wb[i] = '0;
      sda[i] = 1'b0; sdb[i] = 1'b0; idx[i] = 0; hist_a[i] = '0; hist_b[i] = '0;
      start_k[i] = -1000; pend[i] = 0; m_valid[i] = 0;
    end
    repeat (3) step();
    check("rst_cs_n", cs_n[0], 1);
    check("rst_cken", cken[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_valid", valid[0], 0);
    check("rst_data_a", da[0], 0);
    rst = 1'b0;
    repeat (2) step();

    // Basic frame timing relative to the start cycle.
    wa[0] = 16'h2ABC; wb[0] = 16'h1234; start[0] = 1'b1; t0 = cyc;
    step();
    start[0] = 1'b0;
    csf = -1; csl = -1; ckf = -1; ckl = -1; got = 0;
    for (int n = 0; n < 40; n++) begin
      if (!cs_n[0]) begin if (csf < 0) csf = cyc - t0; csl = cyc - t0; end
      if (cken[0]) begin if (ckf < 0) ckf = cyc - t0; ckl = cyc - t0; end
      if (valid[0] && !got) begin got = 1; ga = da[0]; gb = db[0]; end
      step();
    end
    check("cs_n_first_low", csf, 1);
    check("cs_n_last_low", csl, 17);
    check("cken_first", ckf, 2);
    check("cken_last", ckl, 17);
    check("first_valid", got, 1);
    check("first_data_a", ga, 14'h2ABC);
    check("first_data_b", gb, 14'h1234);

    for (int v = 0; v < 6; v++) begin
      run_frame(0, tbl[v].wa, tbl[v].wb, got, ga, gb, lzc, ovc, qc);
      check($sformatf("tbl%0d_valid", v), got, 1);
      check($sformatf("tbl%0d_data_a", v), ga, tbl[v].ea);
      check($sformatf("tbl%0d_data_b", v), gb, tbl[v].eb);
      check($sformatf("tbl%0d_lz_pulses", v), lzc, tbl[v].elz);
    end

    // Overrun: sink stalled across two frames.
    ready[0] = 1'b0;
    run_frame(0, 16'h0001, 16'h0002, got, ga, gb, lzc, ovc, qc);
    check("ovr_first_load", ga, 14'h0001);
    run_frame(0, 16'h3FFF, 16'h3FFF, got, ga, gb, lzc, ovc, qc);
    check("ovr_no_new_valid", got, 0);
    check("ovr_pulses", ovc, 1);
    check("ovr_data_held", da[0], 14'h0001);
    check("ovr_valid_held", valid[0], 1);
    ready[0] = 1'b1;
    step();
    run_frame(0, 16'h1555, 16'h0AAA, got, ga, gb, lzc, ovc, qc);
    check("ovr_after_ready_a", ga, 14'h1555);
    check("ovr_after_ready_b", gb, 14'h0AAA);

    // Start held high: frames back to back at the minimum period.
    wa[0] = 16'h0F0F; wb[0] = 16'h3030; start[0] = 1'b1;
    rises = 0; bad = 0; last_rise = -1; min_gap = 1000; run = 0; seen_low = 0; prev_ck = 0;
    for (int n = 0; n < 130; n++) begin
      step();
      if (cken[0] && !prev_ck) begin
        if (last_rise >= 0 && cyc - last_rise != 21) bad++;
        last_rise = cyc;
        rises++;
      end
      prev_ck = cken[0];
      if (cs_n[0]) run++;
      else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        seen_low = 1;
        run = 0;
      end
    end
    start[0] = 1'b0;
    check("b2b_rises", rises >= 5, 1);
    check("b2b_bad_periods", bad, 0);
    check("b2b_cs_gap_ge2", min_gap >= 2, 1);
    repeat (30) step();

    // Reset during the shift phase.
    wa[0] = 16'h2ABC; wb[0] = 16'h1234; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    cnt = 0;
    for (int n = 0; n < 30 && cnt < 8; n++) begin
      step();
      if (cken[0]) cnt++;
    end
    check("abort_reached_bit8", cnt, 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_cken", cken[0], 0);
    check("abort_busy", busy[0], 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (valid[0]) cnt++;
    end
    check("abort_no_valid", cnt, 0);

    // Long capture delay with short quiet request.
    run_frame(1, 16'h2ABC, 16'h1234, got, ga, gb, lzc, ovc, qc);
    check("d5_quiet_len", qc, 6);
    check("d5_data_a", ga, 14'h2ABC);
    check("d5_data_b", gb, 14'h1234);

    // Randomised traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          wa[i] = 16'($urandom_range(0, 16'h3FFF));
          wb[i] = 16'($urandom_range(0, 16'h3FFF));
          if ($urandom_range(0, 7) == 0) wa[i][15:14] = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) wb[i][15:14] = 2'($urandom_range(0, 3));
        end
        start[i] = ($urandom_range(0, 3) == 0);
        ready[i] = ($urandom_range(0, 2) != 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
